disp_mux_count: RTL
===================

DISP_MUX_COUNT -- requirements
Module: disp_mux_count

Interface
REQ-001 Parameter WIDTH, default 5, SHALL be the bit width of the binary value to display.
REQ-002 Parameter DIGITS, default 2, SHALL be the number of decimal digits driven (1..4).
REQ-003 Parameter SCAN_DIV, default 50000, SHALL be the number of clk cycles each digit stays active.
REQ-004 clk  input  1  SHALL be the rising-edge clock.
REQ-005 rst  input  1  SHALL be the reset, asynchronous, active-high.
REQ-006 value_in  input  WIDTH  SHALL be the binary count sampled on load.
REQ-007 load  input  1  SHALL be the sample strobe, accepted only when ready=1.
REQ-008 ready  output  1  SHALL be high when idle and able to accept load.
REQ-009 bcd_out  output  4*DIGITS  SHALL hold the last converted BCD value, with digit 0 in the LSB nibble.
REQ-010 overflow  output  1  SHALL be high when the last accepted value is >= 10**DIGITS.
REQ-011 seg  output  7  SHALL be the active-low segments in {g,f,e,d,c,b,a} order.
REQ-012 an  output  DIGITS  SHALL be the active-low one-hot digit enables.

Function
REQ-013 Conversion FSM SHALL have states IDLE, SHIFT and UPDATE, with ready=1 only in IDLE.
REQ-014 IDLE with load=1 SHALL capture value_in, clear the BCD shift register, and go to SHIFT.
REQ-015 SHIFT SHALL run shift-add-3 double-dabble for exactly WIDTH cycles, then go to UPDATE.
REQ-016 UPDATE SHALL write bcd_out and overflow in one cycle, then return to IDLE.
REQ-017 bcd_out SHALL change WIDTH+1 cycles after the load-accept edge; ready SHALL rise one cycle later.
REQ-018 load while ready=0 SHALL be ignored, with no queuing.
REQ-019 Overflow SHALL be evaluated on the captured value; when set, bcd_out SHALL hold the truncated low DIGITS digits.
REQ-020 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap.
REQ-021 On each prescaler wrap, the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-022 an SHALL be registered as ~(1<<index) and updated on the same edge as the index.
REQ-023 seg SHALL be registered and SHALL always decode the nibble of the currently enabled digit.
REQ-024 Decode: 0-9 SHALL use the standard glyphs; overflow=1 SHALL force every digit to dash 7'b0111111.
REQ-025 A new bcd_out SHALL take effect on the next seg update and SHALL NOT disturb scan timing.

Reset
REQ-026 rst SHALL force: FSM=IDLE, ready=1, bcd_out=0, overflow=0, prescaler=0, index=0, an=all ones, seg=7'h7F.
REQ-027 rst during SHIFT SHALL abort the conversion and leave bcd_out at 0.
REQ-028 The first an enable SHALL be 1 on digit 0, at prescaler wrap SCAN_DIV cycles after rst deasserts.

Configuration
REQ-029 With LEAD_ZERO_BLANK_EN defined, zero digits above the highest non-zero digit SHALL be blanked (seg=7'h7F); digit 0 SHALL never blank.
REQ-030 Without LEAD_ZERO_BLANK_EN, all digits SHALL display, including leading zeros (7'b1000000).

Structure
REQ-031 Package disp_pkg SHALL hold the FSM state enum typedef, SEG_BLANK=7'h7F, SEG_DASH=7'b0111111 and the 0-9 glyph table.
REQ-032 Sub-module bin2bcd_seq SHALL implement the IDLE/SHIFT/UPDATE conversion; scan and decode stay in the top module.

Verification (WIDTH=5, DIGITS=2, SCAN_DIV=4 unless stated)
REQ-033 Load 27 -> bcd_out=8'h27 six cycles after accept, ready high one cycle later, digit0 seg=7'b1111000.
REQ-034 Free run -> an sequence 2'b11, then 2'b10, then 2'b01, each held 4 cycles, repeating.
REQ-035 Load 12, then load 3 during SHIFT -> second load ignored, final bcd_out=8'h12.
REQ-036 Assert rst at the 3rd SHIFT cycle of load 27 -> all outputs at reset values, ready=1, bcd_out=0.
REQ-037 Load 5 -> digit1 seg=7'h7F with LEAD_ZERO_BLANK_EN, 7'b1000000 without.
REQ-038 WIDTH=7, load 100 -> overflow=1, both digits seg=7'b0111111; then load 42 -> overflow=0, bcd_out=8'h42.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed BCD display block:
// conversion FSM state enum, segment constants and the 0-9 glyph table.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index n holds the glyph for decimal digit n.
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Non-decimal nibbles cannot come out of the converter; blank them anyway.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_BLANK;
    return SEG_GLYPH[nib];
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/disp_mux_count_if.sv
// Bus bundle for disp_mux_count.
// Handshake: a load is accepted on a rising clk edge where load=1 and
// ready=1; while ready=0 a load is dropped, never held or queued, and the
// producer must present it again once ready returns high.
// state mirrors the conversion FSM for observation only.
interface disp_mux_count_if #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
);
  import disp_pkg::*;

  logic [WIDTH-1:0]    value_in;
  logic                load;
  logic                ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                overflow;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  conv_state_t         state;

  modport master (
    output value_in, load,
    input  ready, bcd_out, overflow, seg, an, state
  );

  modport slave (
    input  value_in, load,
    output ready, bcd_out, overflow, seg, an, state
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 double dabble).
// IDLE captures a value, SHIFT runs WIDTH adjust+shift steps, UPDATE
// publishes the result. Only the low DIGITS digits are kept: carries out of
// the top digit are dropped, which leaves the lower digits exact because
// double dabble only ever carries upward.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value_in,
  input  logic                load,
  output logic                ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output conv_state_t         state
);

  // Values at or above this cannot be shown in DIGITS decimal digits.
  localparam int unsigned LIMIT = pow10(DIGITS);
  localparam int          CW    = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic                ovf_calc;

  // Add 3 to every digit that is 5 or more before the next doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Range check on the value being captured (WIDTH is at most 32).
  always_comb begin
    ovf_calc = (32'(value_in) >= LIMIT);
  end

  // Conversion FSM. ready stays low for one IDLE cycle after UPDATE so the
  // fresh bcd_out is visible for a full cycle before the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      bcd_out  <= '0;
      overflow <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load && ready) begin
            bin_q <= value_in;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= ovf_calc;
            ready <= 1'b0;
            state <= SHIFT;
          end else begin
            ready <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state <= UPDATE;
        end
        UPDATE: begin
          bcd_out  <= bcd_q;
          overflow <= ovf_q;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/disp_mux_count.sv
// Multiplexed 7-segment display of a binary count.
// A bin2bcd_seq converts each accepted value; this top scans the digits
// with a SCAN_DIV-cycle prescaler and drives registered segment/anode
// outputs. Optional build macro: LEAD_ZERO_BLANK_EN blanks zero digits
// above the highest non-zero digit (digit 0 always shows).
module disp_mux_count
  import disp_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 50000
) (
  input logic              clk,
  input logic              rst,
  disp_mux_count_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic                ready;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  conv_state_t         state;

  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                lead_zero;
  logic [6:0]          seg_next;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .value_in (bus.value_in),
    .load     (bus.load),
    .ready    (ready),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .state    (state)
  );

  assign bus.ready    = ready;
  assign bus.bcd_out  = bcd_out;
  assign bus.overflow = overflow;
  assign bus.state    = state;
  assign bus.seg      = seg_q;
  assign bus.an       = an_q;

  assign wrap = (pre_q == PW'(SCAN_DIV - 1));

  // Glyph for the digit that becomes enabled at the next wrap.
  always_comb begin
    cur_nib   = bcd_out[int'(idx_q)*4 +: 4];
    lead_zero = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    lead_zero = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_q) && bcd_out[i*4 +: 4] != 4'd0) lead_zero = 1'b0;
    end
`endif
    if (overflow)       seg_next = SEG_DASH;
    else if (lead_zero) seg_next = SEG_BLANK;
    else                seg_next = seg_glyph(cur_nib);
  end

  // Scan: on each prescaler wrap enable digit idx_q, load its glyph and
  // move the index on; anodes and segments therefore change together and
  // a new bcd_out shows up at the next wrap without shifting scan timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else if (wrap) begin
      pre_q <= '0;
      an_q  <= ~(DIGITS'(1) << idx_q);
      seg_q <= seg_next;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule
